// File: rtl/mult32x16_q16_pkg.sv
// mult32x16_q16_pkg: widths and reset value shared by the SID filter multiplier (package sid_mul_pkg)
package sid_mul_pkg;
   localparam int LHS_W  = 32;
   localparam int RHS_W  = 16;
   localparam int FRAC_W = 16;
   localparam int OUT_W  = 32;
   localparam logic [OUT_W-1:0] OUT_RESET = 32'h0;
endpackage

// File: rtl/mult32x16_q16_if.sv
// mult32x16_q16_if: operand/result bundle; iLHS signed sample, iRHS Q0.16 coefficient, oOut scaled product
interface mult32x16_q16_if;
   import sid_mul_pkg::*;
   logic [LHS_W-1:0] iLHS;
   logic [RHS_W-1:0] iRHS;
   logic [OUT_W-1:0] oOut;
   modport master (output iLHS, output iRHS, input oOut);
   modport slave (input iLHS, input iRHS, output oOut);
endinterface

// File: rtl/mul16x16_part.sv
// mul16x16_part: 16x16 partial product; a signed when sgn=1 else unsigned, b always unsigned, p 32-bit exact
module mul16x16_part
   import sid_mul_pkg::*;
(
   input  logic [FRAC_W-1:0]   a,
   input  logic [FRAC_W-1:0]   b,
   input  logic                sgn,
   output logic [2*FRAC_W-1:0] p
);
   logic [2*FRAC_W-1:0] a_x, b_x;
   // the exact product always fits in 32 bits, so the low 32 bits of a wrapped multiply are the result
   assign a_x = {{FRAC_W{sgn & a[FRAC_W-1]}}, a};
   assign b_x = {{FRAC_W{1'b0}}, b};
   assign p   = a_x * b_x;
endmodule

// File: rtl/mult32x16_q16.sv
// mult32x16_q16: registered (signed iLHS * unsigned Q0.16 iRHS) >>> 16; ports clk, rst (async high), bus.slave
module mult32x16_q16
   import sid_mul_pkg::*;
(
   input  logic clk,
   input  logic rst,
   mult32x16_q16_if.slave bus
);
   logic [2*FRAC_W-1:0] p_h, p_l;
   logic [OUT_W-1:0]    sum;
   mul16x16_part u_h (.a(bus.iLHS[LHS_W-1:FRAC_W]), .b(bus.iRHS), .sgn(1'b1), .p(p_h));
   mul16x16_part u_l (.a(bus.iLHS[FRAC_W-1:0]), .b(bus.iRHS), .sgn(1'b0), .p(p_l));
   // low partial is non-negative, so a logical shift floors it; the sum cannot overflow since |result| <= |iLHS|
   assign sum = p_h + (p_l >> FRAC_W);
   always_ff @(posedge clk or posedge rst)
      if (rst) bus.oOut <= OUT_RESET;
      else     bus.oOut <= sum;
endmodule

// File: tb/tb_mult32x16_q16.sv
// tb_mult32x16_q16: table vectors, reset sequence and random pairs checked against a 48-bit reference
module tb_mult32x16_q16;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] sb[$];

   mult32x16_q16_if bus();
   mult32x16_q16 dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] lhs;
      logic [15:0] rhs;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[12];

   function automatic logic [31:0] model(input logic [31:0] lhs, input logic [15:0] rhs);
      logic signed [47:0] a, b, p;
      a = 48'($signed(lhs));
      b = {32'h0, rhs};
      p = a * b;
      return p[47:16];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_pending();
      logic [31:0] e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("pipe", bus.oOut, e);
      end
   endtask

   task automatic apply(input logic [31:0] lhs, input logic [15:0] rhs, input logic [31:0] exp);
      @(negedge clk);
      check_pending();
      bus.iLHS = lhs;
      bus.iRHS = rhs;
      sb.push_back(exp);
   endtask

   task automatic flush();
      @(negedge clk);
      check_pending();
   endtask

   initial begin
      logic [31:0] l;
      logic [15:0] r;
      vecs = '{
         '{32'h00010000, 16'h8000, 32'h00008000},
         '{32'hFFFF0000, 16'h8000, 32'hFFFF8000},
         '{32'hFFFFFFFF, 16'h0001, 32'hFFFFFFFF},
         '{32'h00000001, 16'hFFFF, 32'h00000000},
         '{32'h12345678, 16'h0000, 32'h00000000},
         '{32'h80000000, 16'h0000, 32'h00000000},
         '{32'h7FFFFFFF, 16'hFFFF, 32'h7FFF7FFF},
         '{32'h80000000, 16'hFFFF, 32'h80008000},
         '{32'h80000000, 16'h0001, 32'hFFFF8000},
         '{32'h00020000, 16'h4000, 32'h00008000},
         '{32'h00040000, 16'hBFFF, 32'h0002FFFC},
         '{32'hFFFC0000, 16'h2000, 32'hFFFF8000}
      };
      bus.iLHS = 32'h0;
      bus.iRHS = 16'h0;
      #1 rst = 1'b1;
      #1 chk("reset_state", bus.oOut, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("reset_hold", bus.oOut, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) apply(vecs[i].lhs, vecs[i].rhs, vecs[i].exp);
      flush();
      apply(32'h7FFFFFFF, 16'hFFFF, 32'h7FFF7FFF);
      flush();
      @(posedge clk);
      #2 chk("pre_reset_nonzero", 32'(bus.oOut != 32'h0), 32'h1);
      rst = 1'b1;
      #1 chk("async_clear", bus.oOut, 32'h0);
      bus.iLHS = 32'h00010000;
      bus.iRHS = 16'hFFFF;
      @(negedge clk);
      chk("reset_edge1", bus.oOut, 32'h0);
      @(negedge clk);
      chk("reset_edge2", bus.oOut, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("release_first", bus.oOut, 32'h0000FFFF);
      for (int i = 0; i < 10000; i++) begin
         l = $urandom;
         r = 16'($urandom);
         if (i % 500 == 0) r = 16'hFFFF;
         if (i % 500 == 1) l = 32'h80000000;
         apply(l, r, model(l, r));
      end
      flush();
      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
